pipe_stage_skid: RTL and testbench
==================================

// Module: pipe_stage_skid
// PURPOSE
//   Generic parametrised pipeline stage register for the RV32I pipeline, successor to the fixed IF/ID, ID/EX, EX/MEM, MEM/WB regs.
//   Adds valid/ready handshake, a 2-entry skid buffer (full throughput under backpressure), flush-to-bubble, control masking, stall stats.
//   One instance sits between any two pipeline stages; payload is split into control (masked on bubble) and data (held).
// PARAMETERS
//   DATA_W      32            width of data payload (PC, operands, imm, instruction word)
//   CTRL_W      8             width of control payload (RegWrite, MemRead, MemWrite, ...)
//   NOP_DATA    32'h00000013  data value loaded on reset/flush (RV32I NOP; zero-extended/truncated to DATA_W)
//   CTRL_BUBBLE {CTRL_W{1'b0}} control value driven whenever out_valid=0 (no side effects)
//   STAT_W      16            width of saturating backpressure counter
// PORTS
//   clk          in   1       clock, all state updates on rising edge
//   rst          in   1       synchronous, active-high reset
//   in_valid     in   1       upstream has a payload
//   in_ready     out  1       stage can accept; registered (= skid entry empty)
//   in_ctrl      in   CTRL_W  upstream control payload
//   in_data      in   DATA_W  upstream data payload
//   flush        in   1       kill all held entries (branch/jump redirect)
//   out_valid    out  1       output payload valid
//   out_ready    in   1       downstream accepts (deasserted = stall)
//   out_ctrl     out  CTRL_W  output control; forced CTRL_BUBBLE when out_valid=0
//   out_data     out  DATA_W  output data; holds last value when out_valid=0
//   occupancy    out  2       entries held: 0,1,2
//   stall_cnt    out  STAT_W  cycles with out_valid&&!out_ready, saturating
// BEHAVIOUR
//   Reset (rst=1 at edge): main/skid invalid, out_valid=0, in_ready=1, out_ctrl=CTRL_BUBBLE, out_data=NOP_DATA,
//     occupancy=0, stall_cnt=0. Reset overrides flush and all handshakes; mid-transfer payloads discarded.
//   acc = in_valid&&in_ready; fire = out_valid&&out_ready. Latency in->out = 1 cycle; throughput 1/cycle when out_ready=1.
//   Entries: MAIN drives outputs; SKID holds one overflow payload. FIFO order strictly preserved.
//   Update per edge (no flush):
//     main empty, acc             -> main<=in
//     main full, fire, skid empty -> main<=in if acc else main invalid
//     main full, fire, skid full  -> main<=skid, skid invalid (acc impossible: in_ready=0)
//     main full, !fire, acc       -> skid<=in (in_ready drops next cycle)
//     main full, !fire, !acc      -> hold
//   in_ready = !skid_valid, registered; never combinationally depends on out_ready.
//   Flush: at edge with flush=1 both entries invalidated, data regs<=NOP_DATA, in_ready=1 next cycle;
//     a simultaneous acc payload is dropped; a simultaneous fire still counts as consumed downstream.
//   Flush and stall together: flush wins. stall_cnt still increments that cycle.
//   stall_cnt: +1 per cycle with out_valid&&!out_ready; saturates at 2^STAT_W-1; cleared only by rst.
//   occupancy = main_valid + skid_valid (2-bit), registered view of current state.
//   out_ctrl mux: out_valid ? main_ctrl : CTRL_BUBBLE (combinational from registered state only).
// STRUCTURE
//   Shared package pipe_pkg: RV32I NOP constant (32'h00000013), default bubble control vector, STAT_W default.
//   One sub-module natural: pipe_sat_counter (STAT_W-wide saturating counter with inc/clear), reused by perf stats.
//   Main/skid entries are plain registers in this module; no memory inference.
// TESTING
//   1. rst=1 two cycles -> out_valid=0, in_ready=1, out_data=32'h13, out_ctrl=0, stall_cnt=0, occupancy=0.
//   2. out_ready=1, stream 4 payloads data=1..4 back-to-back -> same order at out, 1-cycle latency, in_ready stays 1.
//   3. Send A,B with out_ready=0 -> occupancy=2, in_ready=0, stall_cnt counts; raise out_ready -> A then B, no loss/dup.
//   4. occupancy=2, flush=1 with in_valid=1 (C) -> next cycle out_valid=0, occupancy=0, out_data=32'h13, C never appears.
//   5. Hold out_valid=1, out_ready=0 for 2^STAT_W+5 cycles (STAT_W=4) -> stall_cnt sticks at 15.
//   6. Assert rst while occupancy=2 and flush=1 -> all reset values next cycle; following stream of data=7 passes cleanly.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared constants for the pipeline stage registers.
package pipe_pkg;

  // RV32I canonical NOP: addi x0, x0, 0
  localparam logic [31:0] RV32I_NOP = 32'h0000_0013;

  // Control defaults: bubble has no side effects (no RegWrite/MemRead/MemWrite)
  localparam int unsigned CTRL_W_DEF      = 8;
  localparam logic [CTRL_W_DEF-1:0] CTRL_BUBBLE_DEF = '0;

  // Default width of the performance counters
  localparam int unsigned STAT_W_DEF = 16;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating event counter with synchronous clear, used for stall statistics.
module pipe_sat_counter
  import pipe_pkg::*;
#(
  parameter int unsigned W = STAT_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise increment until all-ones
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake and a one-entry skid behind
// the main entry, so in_ready can be registered without losing throughput.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int unsigned        DATA_W      = 32,
  parameter int unsigned        CTRL_W      = CTRL_W_DEF,
  parameter logic [DATA_W-1:0]  NOP_DATA    = DATA_W'(RV32I_NOP),
  parameter logic [CTRL_W-1:0]  CTRL_BUBBLE = CTRL_W'(CTRL_BUBBLE_DEF),
  parameter int unsigned        STAT_W      = STAT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [STAT_W-1:0] stall_cnt
);

  logic              main_valid_q, main_valid_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic              skid_valid_q, skid_valid_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;

  logic acc, fire;

  // in_ready comes straight from a flop, never from out_ready
  assign in_ready = ~skid_valid_q;
  assign acc      = in_valid & in_ready;
  assign fire     = main_valid_q & out_ready;

  // Entry next-state: flush drops everything, else advance the main/skid pair in order
  always_comb begin
    main_valid_d = main_valid_q;
    main_ctrl_d  = main_ctrl_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_ctrl_d  = skid_ctrl_q;
    skid_data_d  = skid_data_q;

    if (flush) begin
      main_valid_d = 1'b0;
      main_ctrl_d  = CTRL_BUBBLE;
      main_data_d  = NOP_DATA;
      skid_valid_d = 1'b0;
      skid_ctrl_d  = CTRL_BUBBLE;
      skid_data_d  = NOP_DATA;
    end else if (!main_valid_q) begin
      if (acc) begin
        main_valid_d = 1'b1;
        main_ctrl_d  = in_ctrl;
        main_data_d  = in_data;
      end
    end else if (fire) begin
      if (skid_valid_q) begin
        // in_ready is low here, so no new payload can arrive this cycle
        main_valid_d = 1'b1;
        main_ctrl_d  = skid_ctrl_q;
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
      end else if (acc) begin
        main_valid_d = 1'b1;
        main_ctrl_d  = in_ctrl;
        main_data_d  = in_data;
      end else begin
        // Data is left in place so out_data holds its last value
        main_valid_d = 1'b0;
      end
    end else if (acc) begin
      skid_valid_d = 1'b1;
      skid_ctrl_d  = in_ctrl;
      skid_data_d  = in_data;
    end
  end

  // Entry registers, synchronous reset overrides flush and handshakes
  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      main_ctrl_q  <= CTRL_BUBBLE;
      main_data_q  <= NOP_DATA;
      skid_valid_q <= 1'b0;
      skid_ctrl_q  <= CTRL_BUBBLE;
      skid_data_q  <= NOP_DATA;
    end else begin
      main_valid_q <= main_valid_d;
      main_ctrl_q  <= main_ctrl_d;
      main_data_q  <= main_data_d;
      skid_valid_q <= skid_valid_d;
      skid_ctrl_q  <= skid_ctrl_d;
      skid_data_q  <= skid_data_d;
    end
  end

  assign out_valid = main_valid_q;
  assign out_ctrl  = main_valid_q ? main_ctrl_q : CTRL_BUBBLE;
  assign out_data  = main_data_q;
  assign occupancy = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

  // Backpressure statistic; only reset clears it, flush does not
  pipe_sat_counter #(
    .W (STAT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (1'b0),
    .inc_i (main_valid_q & ~out_ready),
    .cnt_o (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: accepted payloads are queued, the monitor
// pops and compares on every output transfer.
module tb_pipe_stage_skid;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CTRL_W = 8;
  localparam int unsigned STAT_W = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl = '0;
  logic [DATA_W-1:0] in_data = '0;
  logic              flush = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;
  logic [STAT_W-1:0] stall_cnt;

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
  } pay_t;

  pay_t sb_q[$];
  int   n_vec  = 0;
  int   n_err  = 0;
  int   n_pop  = 0;

  always #5 clk = ~clk;

  pipe_stage_skid #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W),
    .STAT_W (STAT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data),
    .occupancy (occupancy),
    .stall_cnt (stall_cnt)
  );

  function automatic logic [CTRL_W-1:0] ctl_of(input logic [DATA_W-1:0] d);
    return d[CTRL_W-1:0] ^ 8'h5A;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DATA_W-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    in_ctrl  = ctl_of(d);
    step();
    in_valid = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " out_valid"}, 32'(out_valid), 32'd0);
    check({tag, " in_ready"},  32'(in_ready),  32'd1);
    check({tag, " out_data"},  out_data,       32'h13);
    check({tag, " out_ctrl"},  32'(out_ctrl),  32'd0);
    check({tag, " stall_cnt"}, 32'(stall_cnt), 32'd0);
    check({tag, " occupancy"}, 32'(occupancy), 32'd0);
  endtask

  // Monitor: inputs are stable between negedge and the next posedge, so what is
  // seen here is exactly what the DUT samples at that edge.
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check("unexpected output", out_data, 32'hDEAD_BEEF);
        end else begin
          pay_t e;
          e = sb_q.pop_front();
          n_pop++;
          check("out_data", out_data, e.data);
          check("out_ctrl", 32'(out_ctrl), 32'(e.ctrl));
        end
      end
      if (!out_valid) check("bubble ctrl", 32'(out_ctrl), 32'd0);
      if (flush) begin
        sb_q.delete();
      end else if (in_valid && in_ready) begin
        sb_q.push_back('{ctrl: in_ctrl, data: in_data});
      end
    end
  end

  initial begin
    // 1. reset
    step();
    step();
    rst = 1'b0;
    check_reset_state("reset");

    // 2. back-to-back stream, 1-cycle latency
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1;
      in_data  = 32'(i);
      in_ctrl  = ctl_of(32'(i));
      step();
      check("stream in_ready",  32'(in_ready),  32'd1);
      check("stream out_valid", 32'(out_valid), 32'd1);
      check("stream latency",   out_data,       32'(i));
    end
    in_valid = 1'b0;
    step();
    check("stream drained", 32'(out_valid), 32'd0);
    check("stream hold data", out_data, 32'd4);

    // 3. backpressure fills skid, then drains in order
    out_ready = 1'b0;
    send(32'hA);
    send(32'hB);
    check("bp occupancy", 32'(occupancy), 32'd2);
    check("bp in_ready",  32'(in_ready),  32'd0);
    check("bp stall 1",   32'(stall_cnt), 32'd1);
    step();
    check("bp stall 2",   32'(stall_cnt), 32'd2);
    check("bp head",      out_data,       32'hA);
    out_ready = 1'b1;
    step();
    check("bp second",    out_data,       32'hB);
    check("bp in_ready back", 32'(in_ready), 32'd1);
    step();
    check("bp empty",     32'(occupancy), 32'd0);

    // 4. flush while full, with a pending input
    out_ready = 1'b0;
    send(32'hD);
    send(32'hE);
    check("pre-flush occupancy", 32'(occupancy), 32'd2);
    in_valid = 1'b1;
    in_data  = 32'hC;
    in_ctrl  = ctl_of(32'hC);
    flush    = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush out_valid", 32'(out_valid), 32'd0);
    check("flush occupancy", 32'(occupancy), 32'd0);
    check("flush out_data",  out_data,       32'h13);
    check("flush in_ready",  32'(in_ready),  32'd1);
    check("flush stall",     32'(stall_cnt), 32'd4);
    out_ready = 1'b1;
    step();
    step();
    check("flush no C", 32'(out_valid), 32'd0);

    // 5. stall counter saturation
    out_ready = 1'b0;
    send(32'hF);
    for (int i = 0; i < 10; i++) step();
    check("stall pre-sat", 32'(stall_cnt), 32'd14);
    for (int i = 0; i < 11; i++) step();
    check("stall saturated", 32'(stall_cnt), 32'd15);
    out_ready = 1'b1;
    step();
    check("stall sticks", 32'(stall_cnt), 32'd15);

    // 6. reset over flush while full
    out_ready = 1'b0;
    send(32'h10);
    send(32'h11);
    check("pre-reset occupancy", 32'(occupancy), 32'd2);
    in_valid = 1'b1;
    in_data  = 32'h12;
    in_ctrl  = ctl_of(32'h12);
    flush    = 1'b1;
    rst      = 1'b1;
    step();
    rst      = 1'b0;
    flush    = 1'b0;
    in_valid = 1'b0;
    check_reset_state("rst-flush");
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send(32'd7);
      check("post-reset stream", out_data, 32'd7);
    end
    step();
    step();

    check("total transfers", 32'(n_pop), 32'd10);
    check("scoreboard empty", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
